// File: rtl/io_sel_ctrl_if.sv
// rtl/io_sel_ctrl_if.sv - register bus bundle between the system bus and io_sel_ctrl
interface io_sel_ctrl_if;
    logic        wr_en;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output wr_en, output addr, output wdata, input rdata);
    modport slave  (input wr_en, input addr, input wdata, output rdata);
endinterface

// File: rtl/io_sel_ctrl.sv
// rtl/io_sel_ctrl.sv - glitch-free owner of the shared-pin select vector io_sel[23:11]
module io_sel_ctrl #(
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    io_sel_ctrl_if.slave       bus,
    input  logic               spi1_busy,
    input  logic               spi2_busy,
    input  logic               i2c_busy,
    input  logic               ptc_busy,
    output logic [12:0]        io_sel,
    output logic [12:0]        hiz_mask,
    output logic               ctrl_busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        GUARD     = 2'd2,
        APPLY     = 2'd3
    } state_t;

    localparam logic [7:0]  GUARD_LOAD = 8'(GUARD_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [12:0] sel_req, sel_req_nxt;
    logic [12:0] io_sel_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic [7:0]  guard_cnt, guard_cnt_nxt;
    logic        timeout_err, reject_err;
    logic        timeout_set, reject_set;
    logic [12:0] changed;
    logic        need_idle;
    logic        sel_write, status_write;
    logic        unused_wdata;

    assign sel_write    = bus.wr_en && (bus.addr == 2'd0);
    assign status_write = bus.wr_en && (bus.addr == 2'd2);
    assign unused_wdata = ^{bus.wdata[31:13]};

    assign changed   = sel_req ^ io_sel;
    // Only peripherals whose pins actually move have to be quiet.
    assign need_idle = ((|changed[4:0])  & spi2_busy)
                     | ((|changed[6:5])  & i2c_busy)
                     | (changed[7]       & ptc_busy)
                     | ((|changed[12:8]) & spi1_busy);

    assign ctrl_busy  = (state != IDLE);
    assign reject_set = sel_write && (state != IDLE);

    always_comb begin
        state_nxt     = state;
        sel_req_nxt   = sel_req;
        io_sel_nxt    = io_sel;
        wait_cnt_nxt  = wait_cnt;
        guard_cnt_nxt = guard_cnt;
        timeout_set   = 1'b0;
        hiz_mask      = 13'd0;
        case (state)
            IDLE: begin
                if (sel_write) begin
                    sel_req_nxt = bus.wdata[12:0];
                    if (bus.wdata[12:0] != io_sel) begin
                        state_nxt    = WAIT_IDLE;
                        wait_cnt_nxt = 16'd0;
                    end
                end
            end
            WAIT_IDLE: begin
                if (!need_idle) begin
                    state_nxt     = GUARD;
                    guard_cnt_nxt = GUARD_LOAD;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Abort leaves the pins untouched and forgets the request.
                    state_nxt    = IDLE;
                    timeout_set  = 1'b1;
                    sel_req_nxt  = io_sel;
                    wait_cnt_nxt = 16'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            GUARD: begin
                hiz_mask = changed;
                if (guard_cnt == 8'd0) begin
                    state_nxt = APPLY;
                end else begin
                    guard_cnt_nxt = guard_cnt - 8'd1;
                end
            end
            APPLY: begin
                hiz_mask   = changed;
                io_sel_nxt = sel_req;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sel_req     <= 13'd0;
            io_sel      <= 13'd0;
            wait_cnt    <= 16'd0;
            guard_cnt   <= 8'd0;
            timeout_err <= 1'b0;
            reject_err  <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel_req     <= sel_req_nxt;
            io_sel      <= io_sel_nxt;
            wait_cnt    <= wait_cnt_nxt;
            guard_cnt   <= guard_cnt_nxt;
            // A new error event beats a simultaneous clear.
            timeout_err <= timeout_set | (timeout_err & ~(status_write & bus.wdata[1]));
            reject_err  <= reject_set  | (reject_err  & ~(status_write & bus.wdata[2]));
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            2'd0:    bus.rdata = {19'd0, sel_req};
            2'd1:    bus.rdata = {19'd0, io_sel};
            2'd2:    bus.rdata = {29'd0, reject_err, timeout_err, ctrl_busy};
            default: bus.rdata = 32'd0;
        endcase
    end

endmodule

// File: doc/io_sel_ctrl.md
Name: io_sel_ctrl

Overview:
Register-programmed controller that owns the 13-bit shared-pin select vector, io_sel[23:11], driven into the pad io mux. It hands pin groups between GPIO and the SPI1, SPI2, I2C and PTC peripherals without glitches. On each change it waits for the affected peripherals to go idle, then holds the changing pins hi-Z for a guard period, then commits the new selection. It sits between the system register bus and the io mux.

Parameters:
GUARD_CYCLES, 4, cycles the changing pins are held hi-Z before commit (1..255)
TIMEOUT_CYCLES, 1024, maximum cycles spent waiting for peripheral idle before abort (1..65535)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  register write strobe, single cycle
addr  in  2  register address
wdata  in  32  write data
rdata  out  32  read data, combinational from addr
spi1_busy  in  1  flash SPI transfer in progress (pins 19-23)
spi2_busy  in  1  SPI2 transfer in progress (pins 11-15)
i2c_busy  in  1  I2C transaction in progress (pins 16-17)
ptc_busy  in  1  PWM output active (pin 18)
io_sel  out  13  committed select, bit k maps to pin k+11
hiz_mask  out  13  1 = force pad output-enable to input/hi-Z (en_gpio=1) for pin k+11
ctrl_busy  out  1  high when FSM is not IDLE

Behaviour:
- Clock and reset: one clock (clk). reset_n is asynchronous, active-low.
- Reset values: io_sel=0 (all pins GPIO), hiz_mask=0, ctrl_busy=0, sel_req=0, error flags=0, FSM=IDLE, counters=0.
- Register map:
  - addr0 SEL_REQ: RW, bits[12:0]; upper bits read 0.
  - addr1 SEL_ACT: RO, equals io_sel.
  - addr2 STATUS: [0] busy (RO), [1] timeout_err (W1C), [2] reject_err (W1C).
  - addr3: reads 0, writes ignored.
- changed = sel_req XOR io_sel.
- Groups: G_SPI2=bits[4:0], G_I2C=[6:5], G_PTC=[7], G_SPI1=[12:8].
- need_idle = OR of the busy inputs of every group with any changed bit.
- FSM:
  - IDLE: a SEL_REQ write with value != io_sel loads sel_req and moves to WAIT_IDLE next cycle. A write equal to io_sel loads sel_req and stays in IDLE.
  - WAIT_IDLE: each cycle, if need_idle==0, go to GUARD and load guard counter with GUARD_CYCLES-1. Otherwise increment the wait counter; when it reaches TIMEOUT_CYCLES-1 with need_idle still 1, go to IDLE, set timeout_err, and restore sel_req=io_sel. io_sel is unchanged on abort.
  - GUARD: hiz_mask=changed. The counter decrements; at 0, go to APPLY. Busy inputs are ignored here.
  - APPLY: io_sel<=sel_req on the exit edge, hiz_mask stays = changed for this cycle, then IDLE. hiz_mask=0 in IDLE.
- Latency with all peripherals idle: write sampled at edge T.
  - WAIT_IDLE during cycle T+1.
  - GUARD during cycles T+2 .. T+1+GUARD_CYCLES.
  - APPLY during T+2+GUARD_CYCLES.
  - New io_sel visible from T+3+GUARD_CYCLES; hiz_mask deasserts in the same cycle.
- Unchanged pins never see hiz_mask set, and never see an io_sel glitch.
- SEL_REQ write while not IDLE: ignored, reject_err set, sequence continues.
- Error flags: same-cycle set and W1C on the same flag: set wins.
- ctrl_busy = (state != IDLE) = STATUS[0].
- Busy inputs are synchronous to clk; no synchronizers are required.
- Reset asserted mid-sequence: everything returns to reset values immediately, including io_sel=0 and hiz_mask=0.

Test Plan:
1. Reset, then write SEL_REQ=0x1FFF with all busy=0, GUARD_CYCLES=4 -> hiz_mask=0x1FFF for 5 cycles; io_sel=0x1FFF at T+7; SEL_ACT reads 0x1FFF; STATUS=0.
2. io_sel=0, spi2_busy=1, write 0x0020 -> proceeds without waiting (I2C group only changes); hiz_mask=0x0020 only; io_sel=0x0020.
3. io_sel=0, spi1_busy=1, write 0x1F00, drop spi1_busy after 50 cycles -> GUARD starts the cycle after the drop; io_sel=0x1F00; timeout_err=0.
4. TIMEOUT_CYCLES=16, spi1_busy stuck 1, write 0x1F00 -> abort after 16 WAIT cycles; io_sel=0, SEL_REQ reads 0, STATUS=0x2; write 0x2 to STATUS -> 0x0.
5. Second SEL_REQ write during GUARD -> ignored; STATUS bit2=1; the first request commits unchanged.
6. reset_n low during GUARD after a 0x0->0x00FF request -> io_sel=0, hiz_mask=0, ctrl_busy=0 asynchronously; no commit after reset release.
